// File: rtl/alu_mul_seq.sv
// Unsigned 16x16->32 shift-add multiplier that borrows the CPU ALU for its adds.
// Latency: start sampled at edge 0, done pulses in cycle 34 (cycle 33 without flag restore).
// Backpressure: holds stall/busy for the whole operation; start while busy is dropped, not queued.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start, op_a, op_b          request and operands (latched when start is accepted in IDLE)
//   busy, done, product, stall status, one-cycle completion pulse, held result, pipeline stall
//   alu_own, alu_in_a/b, alu_op, alu_i_field, alu_h_en/l_en, alu_set_cc, alu_data_hazard
//                              drive towards the shared ALU input muxes
//   alu_out, alu_n/z/p/c       registered ALU result and flags
module alu_mul_seq #(
    parameter bit RESTORE_FLAGS = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product,
    output logic        stall,
    output logic        alu_own,
    output logic [15:0] alu_in_a,
    output logic [15:0] alu_in_b,
    output logic [3:0]  alu_op,
    output logic [7:0]  alu_i_field,
    output logic        alu_h_en,
    output logic        alu_l_en,
    output logic        alu_set_cc,
    output logic        alu_data_hazard,
    input  logic [15:0] alu_out,
    input  logic        alu_n,
    input  logic        alu_z,
    input  logic        alu_p,
    input  logic        alu_c
);

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_NOP = 4'b0111;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADD     = 3'd1,
        S_SHIFT   = 3'd2,
        S_RESTORE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [15:0] mcand;
    logic [15:0] mplier;      // multiplier, shifted out as the low product half shifts in
    logic [15:0] acc_hi;
    logic [3:0]  count;
    logic [3:0]  flags_s;     // saved {c, n, z, p}
    logic [31:0] product_r;

    // One right shift of the 33-bit {carry, sum, mplier} value produced by the last ADD.
    logic [15:0] shift_hi;
    logic [15:0] shift_lo;

    assign shift_hi = {alu_c, alu_out[15:1]};
    assign shift_lo = {alu_out[0], mplier[15:1]};

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (start) state_next = S_ADD;
            S_ADD:     state_next = S_SHIFT;
            S_SHIFT: begin
                if (count == 4'd15)
                    state_next = RESTORE_FLAGS ? S_RESTORE : S_DONE;
                else
                    state_next = S_ADD;
            end
            S_RESTORE: state_next = S_DONE;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand     <= 16'h0000;
            mplier    <= 16'h0000;
            acc_hi    <= 16'h0000;
            count     <= 4'd0;
            flags_s   <= 4'h0;
            product_r <= 32'h0000_0000;
        end else begin
            if (state == S_IDLE && start) begin
                mcand  <= op_a;
                mplier <= op_b;
                acc_hi <= 16'h0000;
                count  <= 4'd0;
                if (RESTORE_FLAGS)
                    flags_s <= {alu_c, alu_n, alu_z, alu_p};
            end
            if (state == S_SHIFT) begin
                acc_hi <= shift_hi;
                mplier <= shift_lo;
                count  <= count + 4'd1;
            end
            // Result register is loaded on entry to DONE so it is valid with the done pulse.
            if (state_next == S_DONE && state != S_DONE) begin
                if (state == S_SHIFT) product_r <= {shift_hi, shift_lo};
                else                  product_r <= {acc_hi, mplier};
            end
        end
    end

    // ALU drive and status outputs
    always_comb begin
        alu_own         = 1'b0;
        alu_in_a        = 16'h0000;
        alu_in_b        = 16'h0000;
        alu_op          = ALU_NOP;
        alu_h_en        = 1'b1;
        alu_l_en        = 1'b1;
        alu_set_cc      = 1'b0;
        alu_data_hazard = 1'b1;
        case (state)
            S_ADD: begin
                alu_own         = 1'b1;
                alu_data_hazard = 1'b0;
                alu_op          = ALU_ADD;
                alu_in_a        = acc_hi;
                alu_in_b        = mplier[0] ? mcand : 16'h0000;
            end
            S_SHIFT: begin
                // Bubble cycle: the ALU output register now holds the ADD result.
                alu_own = 1'b1;
            end
            S_RESTORE: begin
                alu_own         = 1'b1;
                alu_data_hazard = 1'b0;
                alu_set_cc      = 1'b1;
                alu_in_a        = {12'h000, flags_s};
            end
            default: ;
        endcase
    end

    assign alu_i_field = 8'h00;
    assign busy        = (state != S_IDLE);
    assign stall       = busy;
    assign done        = (state == S_DONE);
    assign product     = product_r;

endmodule

// File: tb/tb_alu_mul_seq.sv
module tb_alu_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] op_a, op_b;
    logic        busy, done, stall, alu_own;
    logic [31:0] product;
    logic [15:0] alu_in_a, alu_in_b;
    logic [3:0]  alu_op;
    logic [7:0]  alu_i_field;
    logic        alu_h_en, alu_l_en, alu_set_cc, alu_data_hazard;
    logic [15:0] alu_out = 16'h0000;
    logic        alu_n = 1'b0, alu_z = 1'b0, alu_p = 1'b0, alu_c = 1'b0;

    // CPU-side flag write used when the multiplier does not own the ALU
    logic        cpu_set_cc = 1'b0;
    logic [3:0]  cpu_flags  = 4'h0;   // {c, n, z, p}

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_mul_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .product(product), .stall(stall),
        .alu_own(alu_own), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
        .alu_op(alu_op), .alu_i_field(alu_i_field), .alu_h_en(alu_h_en),
        .alu_l_en(alu_l_en), .alu_set_cc(alu_set_cc), .alu_data_hazard(alu_data_hazard),
        .alu_out(alu_out), .alu_n(alu_n), .alu_z(alu_z), .alu_p(alu_p), .alu_c(alu_c)
    );

    // Behavioural ALU: registered add with flags, set_cc reloads flags from in_a[3:0].
    logic [16:0] alu_sum;
    always @(posedge clk) begin
        if (alu_own) begin
            if (!alu_data_hazard && alu_set_cc) begin
                {alu_c, alu_n, alu_z, alu_p} <= alu_in_a[3:0];
            end else if (!alu_data_hazard && alu_op == 4'b0000) begin
                alu_sum = {1'b0, alu_in_a} + {1'b0, alu_in_b};
                alu_out <= alu_sum[15:0];
                alu_c   <= alu_sum[16];
                alu_n   <= alu_sum[15];
                alu_z   <= (alu_sum[15:0] == 16'h0000);
                alu_p   <= !alu_sum[15] && (alu_sum[15:0] != 16'h0000);
            end
        end else if (cpu_set_cc) begin
            {alu_c, alu_n, alu_z, alu_p} <= cpu_flags;
        end
    end

    // Observations from the most recent run_op
    int          done_cyc;
    int          n_done;
    int          busy_err;
    int          adds;
    int          inb_nonzero;
    logic [31:0] prod_seen;

    // Issue one multiply (start pulsed for one edge), watch 40 cycles afterwards.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b);
        done_cyc = -1; n_done = 0; busy_err = 0; adds = 0; inb_nonzero = 0;
        prod_seen = 32'hxxxx_xxxx;
        @(negedge clk);
        op_a = a; op_b = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a = 16'($urandom); op_b = 16'($urandom);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (busy !== (cyc <= 34) || stall !== (cyc <= 34)) busy_err++;
            if (alu_own && !alu_data_hazard && alu_op == 4'b0000) begin
                adds++;
                if (alu_in_b !== 16'h0000) inb_nonzero++;
            end
            if (done === 1'b1) begin
                n_done++;
                done_cyc = cyc;
                prod_seen = product;
            end
            op_a = 16'($urandom); op_b = 16'($urandom);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; op_a = 16'h0; op_b = 16'h0;
        #3;
        n_tests++; if ({busy, done, stall, alu_own} !== 4'b0000) begin n_fail++;
            $display("FAIL reset_status got=%b want=0000", {busy, done, stall, alu_own}); end
        n_tests++; if (product !== 32'h0) begin n_fail++;
            $display("FAIL reset_product got=%h want=00000000", product); end
        n_tests++; if ({alu_op, alu_h_en, alu_l_en, alu_set_cc, alu_data_hazard} !== 8'b0111_1101) begin n_fail++;
            $display("FAIL reset_alu_ctl got=%b want=01111101", {alu_op, alu_h_en, alu_l_en, alu_set_cc, alu_data_hazard}); end
        n_tests++; if ({alu_in_a, alu_in_b, alu_i_field} !== 40'h0) begin n_fail++;
            $display("FAIL reset_alu_data got=%h want=0", {alu_in_a, alu_in_b, alu_i_field}); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        run_op(16'h0003, 16'h0005);
        n_tests++; if (done_cyc != 34) begin n_fail++;
            $display("FAIL basic_latency got=%0d want=34", done_cyc); end
        n_tests++; if (prod_seen !== 32'h0000_000F) begin n_fail++;
            $display("FAIL basic_product got=%h want=0000000f", prod_seen); end
        n_tests++; if (busy_err != 0) begin n_fail++;
            $display("FAIL basic_busy_window got=%0d bad cycles want=0", busy_err); end
        n_tests++; if (n_done != 1) begin n_fail++;
            $display("FAIL basic_done_count got=%0d want=1", n_done); end
        n_tests++; if (product !== 32'h0000_000F) begin n_fail++;
            $display("FAIL basic_product_held got=%h want=0000000f", product); end
        n_tests++; if (alu_own !== 1'b0) begin n_fail++;
            $display("FAIL basic_alu_returned got=%b want=0", alu_own); end
    endtask

    task automatic test_corners;
        run_op(16'hFFFF, 16'hFFFF);
        n_tests++; if (prod_seen !== 32'hFFFE_0001 || done_cyc != 34) begin n_fail++;
            $display("FAIL max_product got=%h@%0d want=fffe0001@34", prod_seen, done_cyc); end
        run_op(16'h0000, 16'hABCD);
        n_tests++; if (prod_seen !== 32'h0) begin n_fail++;
            $display("FAIL zero_product got=%h want=00000000", prod_seen); end
        n_tests++; if (adds != 16 || inb_nonzero != 0) begin n_fail++;
            $display("FAIL zero_adds got adds=%0d nonzero_in_b=%0d want 16/0", adds, inb_nonzero); end
        run_op(16'hABCD, 16'h0001);
        n_tests++; if (prod_seen !== 32'h0000_ABCD) begin n_fail++;
            $display("FAIL one_product got=%h want=0000abcd", prod_seen); end
    endtask

    task automatic test_flags;
        @(negedge clk);
        cpu_flags = 4'b1010; cpu_set_cc = 1'b1;
        @(negedge clk);
        cpu_set_cc = 1'b0;
        run_op(16'h8000, 16'h0002);
        n_tests++; if (prod_seen !== 32'h0001_0000) begin n_fail++;
            $display("FAIL flags_product got=%h want=00010000", prod_seen); end
        n_tests++; if ({alu_c, alu_n, alu_z, alu_p} !== 4'b1010) begin n_fail++;
            $display("FAIL flags_restored got=%b want=1010", {alu_c, alu_n, alu_z, alu_p}); end
        @(negedge clk);
        cpu_flags = 4'b0001; cpu_set_cc = 1'b1;
        @(negedge clk);
        cpu_set_cc = 1'b0;
        run_op(16'h1234, 16'h5678);
        n_tests++; if ({alu_c, alu_n, alu_z, alu_p} !== 4'b0001) begin n_fail++;
            $display("FAIL flags_restored2 got=%b want=0001", {alu_c, alu_n, alu_z, alu_p}); end
    endtask

    task automatic test_random;
        logic [15:0] a, b;
        logic [31:0] exp;
        for (int i = 0; i < 8; i++) begin
            a = 16'($urandom); b = 16'($urandom);
            exp = 32'(a) * 32'(b);
            run_op(a, b);
            n_tests++; if (prod_seen !== exp || done_cyc != 34 || n_done != 1) begin n_fail++;
                $display("FAIL random_%0d %h*%h got=%h@%0d x%0d want=%h@34 x1",
                         i, a, b, prod_seen, done_cyc, n_done, exp); end
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] a, b;
        @(negedge clk);
        op_a = 16'h4321; op_b = 16'h0F0F; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc < 10; cyc++) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++; if ({busy, stall, alu_own, done} !== 4'b0000) begin n_fail++;
            $display("FAIL midreset_status got=%b want=0000", {busy, stall, alu_own, done}); end
        n_tests++; if (product !== 32'h0) begin n_fail++;
            $display("FAIL midreset_product got=%h want=00000000", product); end
        @(negedge clk);
        rst_n = 1'b1;
        a = 16'($urandom); b = 16'($urandom);
        run_op(a, b);
        n_tests++; if (prod_seen !== 32'(a) * 32'(b) || done_cyc != 34) begin n_fail++;
            $display("FAIL midreset_recover got=%h@%0d want=%h@34", prod_seen, done_cyc, 32'(a) * 32'(b)); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] a1, b1, a2, b2;
        int          dq[$];
        logic [31:0] pq[$];
        a1 = 16'($urandom); b1 = 16'($urandom);
        a2 = 16'($urandom); b2 = 16'($urandom);
        @(negedge clk);
        op_a = a1; op_b = b1; start = 1'b1;
        @(posedge clk);
        #1 op_a = 16'($urandom); op_b = 16'($urandom);
        for (int cyc = 1; cyc <= 75; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dq.push_back(cyc);
                pq.push_back(product);
            end
            if (cyc == 35) begin
                op_a = a2; op_b = b2;
            end else begin
                op_a = 16'($urandom); op_b = 16'($urandom);
            end
            if (cyc == 36) start = 1'b0;
        end
        n_tests++; if (dq.size() != 2) begin n_fail++;
            $display("FAIL b2b_done_count got=%0d want=2", dq.size()); end
        else begin
            n_tests++; if (dq[0] != 34 || dq[1] != 69) begin n_fail++;
                $display("FAIL b2b_done_cycles got=%0d,%0d want=34,69", dq[0], dq[1]); end
            n_tests++; if (pq[0] !== 32'(a1) * 32'(b1)) begin n_fail++;
                $display("FAIL b2b_first_product got=%h want=%h", pq[0], 32'(a1) * 32'(b1)); end
            n_tests++; if (pq[1] !== 32'(a2) * 32'(b2)) begin n_fail++;
                $display("FAIL b2b_second_product got=%h want=%h", pq[1], 32'(a2) * 32'(b2)); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_flags();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
